// File: rtl/greyscale_pipe_if.sv
// Pixel stream bundle for greyscale_pipe: upstream RGB + valid/ready in,
// downstream RGB + valid/ready out. Names are from the DUT's point of view.
interface greyscale_pipe_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] i_red, i_green, i_blue;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_red, o_green, o_blue;
  logic              o_valid;
  logic              i_ready;

  modport slave (
    input  i_red, i_green, i_blue, i_valid, i_ready,
    output o_ready, o_red, o_green, o_blue, o_valid
  );

  modport master (
    output i_red, i_green, i_blue, i_valid, i_ready,
    input  o_ready, o_red, o_green, o_blue, o_valid
  );
endinterface

// File: rtl/greyscale_pipe.sv
// Two-stage RGB-to-greyscale converter with programmable weights, output mode and full
// backpressure. Define GREYSCALE_THRESH_EN to turn mode 3 into a threshold against i_thresh.
module greyscale_pipe #(
  parameter int DATA_W      = 12,
  parameter int WEIGHT_W    = 4,
  parameter int SHIFT       = 3,
  parameter int W_RED_DEF   = 3,
  parameter int W_GREEN_DEF = 3,
  parameter int W_BLUE_DEF  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  greyscale_pipe_if.slave     pix,
  input  logic                i_cfg_load,
  input  logic [1:0]          i_mode,
  input  logic [WEIGHT_W-1:0] i_w_red,
  input  logic [WEIGHT_W-1:0] i_w_green,
  input  logic [WEIGHT_W-1:0] i_w_blue,
  input  logic [DATA_W-1:0]   i_thresh,
  output logic [31:0]         o_pix_count
);
  localparam int STAGES = 2;
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int SUM_W  = DATA_W + WEIGHT_W + 2;
  localparam logic [DATA_W-1:0] MAXV = '1;

  logic                           w_adv;
  logic [STAGES:1]                r_vld_pipe;
  logic [2:0][DATA_W-1:0]         w_pix_in, r_rgb_s1, w_out, r_out;
  logic [2:0][WEIGHT_W-1:0]       r_w;
  logic [2:0][PROD_W-1:0]         r_prod;
  logic [1:0]                     r_mode, r_mode_s1;
  logic [SUM_W-1:0]               w_sum, w_shift;
  logic [DATA_W-1:0]              w_grey;
  logic [31:0]                    r_pix_count;

  // Channel index 2 = red, 1 = green, 0 = blue.
  assign w_pix_in    = {pix.i_red, pix.i_green, pix.i_blue};
  assign w_adv       = ~r_vld_pipe[STAGES] | pix.i_ready;
  assign pix.o_ready = w_adv;
  assign pix.o_valid = r_vld_pipe[STAGES];
  assign {pix.o_red, pix.o_green, pix.o_blue} = r_out;
  assign o_pix_count = r_pix_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w    <= {WEIGHT_W'(W_RED_DEF), WEIGHT_W'(W_GREEN_DEF), WEIGHT_W'(W_BLUE_DEF)};
      r_mode <= 2'd1;
    end else if (i_cfg_load) begin
      r_w    <= {i_w_red, i_w_green, i_w_blue};
      r_mode <= i_mode;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix.i_valid};
  end

  // S1 datapath needs no reset: its contents only matter behind a set valid bit.
  always_ff @(posedge i_clk) begin
    if (w_adv) begin
      for (int c = 0; c < 3; c++)
        r_prod[c] <= PROD_W'(w_pix_in[c]) * PROD_W'(r_w[c]);
      r_rgb_s1  <= w_pix_in;
      r_mode_s1 <= r_mode;
    end
  end

`ifdef GREYSCALE_THRESH_EN
  logic [DATA_W-1:0] r_thresh_s1;
  always_ff @(posedge i_clk) begin
    if (w_adv) r_thresh_s1 <= i_thresh;
  end
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^i_thresh;
`endif

  assign w_sum   = SUM_W'(r_prod[0]) + SUM_W'(r_prod[1]) + SUM_W'(r_prod[2]);
  assign w_shift = w_sum >> SHIFT;
  assign w_grey  = (w_shift > SUM_W'(MAXV)) ? MAXV : w_shift[DATA_W-1:0];

  always_comb begin
    w_out = r_rgb_s1;
    case (r_mode_s1)
      2'd0: w_out = r_rgb_s1;
      2'd1: w_out = {3{w_grey}};
      2'd2: w_out = {3{MAXV - w_grey}};
`ifdef GREYSCALE_THRESH_EN
      2'd3: w_out = (w_grey >= r_thresh_s1) ? {3{MAXV}} : '0;
`else
      2'd3: w_out = {3{w_grey}};
`endif
      default: w_out = r_rgb_s1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_out <= '0;
    else if (w_adv) r_out <= w_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                           r_pix_count <= '0;
    else if (pix.o_valid && pix.i_ready) r_pix_count <= r_pix_count + 32'd1;
  end
endmodule

// File: tb/tb_greyscale_pipe.sv
// Scoreboard bench for greyscale_pipe: driver pushes model results on input handshakes,
// a separate monitor pops and compares on output handshakes.
module tb_greyscale_pipe;
  localparam int DW   = 12;
  localparam int WW   = 4;
  localparam int SH   = 3;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  greyscale_pipe_if #(.DATA_W(DW)) pix ();
  logic          cfg_load;
  logic [1:0]    mode;
  logic [WW-1:0] wr, wg, wb;
  logic [DW-1:0] thresh;
  logic [31:0]   pix_count;

  greyscale_pipe #(.DATA_W(DW), .WEIGHT_W(WW), .SHIFT(SH),
                   .W_RED_DEF(3), .W_GREEN_DEF(3), .W_BLUE_DEF(2)) dut (
    .i_clk(clk), .i_rst(rst), .pix(pix),
    .i_cfg_load(cfg_load), .i_mode(mode),
    .i_w_red(wr), .i_w_green(wg), .i_w_blue(wb),
    .i_thresh(thresh), .o_pix_count(pix_count)
  );

  typedef struct { int r; int g; int b; } px_t;
  px_t exp_q[$];

  int nchk = 0, nerr = 0;
  int m_wr = 3, m_wg = 3, m_wb = 2, m_mode = 1;
  int m_cnt = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  function automatic px_t model(int r, int g, int b, int mw_r, int mw_g, int mw_b,
                                int md, int thr);
    px_t p;
    int grey;
    grey = (r * mw_r + g * mw_g + b * mw_b) / (1 << SH);
    if (grey > MAXV) grey = MAXV;
    p = '{grey, grey, grey};
    if (md == 0) p = '{r, g, b};
    else if (md == 2) p = '{MAXV - grey, MAXV - grey, MAXV - grey};
`ifdef GREYSCALE_THRESH_EN
    else if (md == 3) begin
      if (grey >= thr) p = '{MAXV, MAXV, MAXV};
      else             p = '{0, 0, 0};
    end
`endif
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock: set i_ready, sample handshakes ahead of the posedge, return at the next negedge.
  task automatic cycle(output bit acc);
    case (rdy_mode)
      0: pix.i_ready = 1'b1;
      1: pix.i_ready = ($urandom_range(0, 3) != 0);
      default: pix.i_ready = 1'b0;
    endcase
    #1;
    acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_wr = 3; m_wg = 3; m_wb = 2; m_mode = 1;
    end else begin
      if (pix.i_valid && pix.o_ready) begin
        exp_q.push_back(model(int'(pix.i_red), int'(pix.i_green), int'(pix.i_blue),
                              m_wr, m_wg, m_wb, m_mode, int'(thresh)));
        acc = 1'b1;
      end
      if (cfg_load) begin
        m_wr = int'(wr); m_wg = int'(wg); m_wb = int'(wb); m_mode = int'(mode);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int r, input int g, input int b);
    bit acc;
    acc = 1'b0;
    pix.i_red = DW'(r); pix.i_green = DW'(g); pix.i_blue = DW'(b);
    pix.i_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) begin
      cycle(acc);
      cfg_load = 1'b0;
    end
    if (!acc) begin
      nchk++; nerr++;
      $display("FAIL send_timeout: got no accept expected accept within 64 cycles");
    end
    pix.i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) begin
      pix.i_valid = 1'b0;
      pix.i_red = DW'($urandom); pix.i_green = DW'($urandom); pix.i_blue = DW'($urandom);
      cycle(acc);
      cfg_load = 1'b0;
    end
  endtask

  task automatic load_cfg(input int lr, input int lg, input int lb, input int lm);
    wr = WW'(lr); wg = WW'(lg); wb = WW'(lb); mode = 2'(lm);
    cfg_load = 1'b1;
    idle(1);
  endtask

  // Monitor: checks the ready rule, output stability under stall, and output handshakes.
  initial begin
    px_t e;
    bit prev_stall;
    int pr, pg, pb;
    prev_stall = 1'b0;
    pr = 0; pg = 0; pb = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        chk("ready_rule", int'(pix.o_ready), int'(!pix.o_valid || pix.i_ready));
        if (prev_stall) begin
          chk("hold_valid", int'(pix.o_valid), 1);
          chk("hold_red", int'(pix.o_red), pr);
          chk("hold_green", int'(pix.o_green), pg);
          chk("hold_blue", int'(pix.o_blue), pb);
        end
        if (pix.o_valid && pix.i_ready) begin
          if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_out: got pixel %0h/%0h/%0h expected none",
                     pix.o_red, pix.o_green, pix.o_blue);
          end else begin
            e = exp_q.pop_front();
            chk("out_red", int'(pix.o_red), e.r);
            chk("out_green", int'(pix.o_green), e.g);
            chk("out_blue", int'(pix.o_blue), e.b);
            chk("pix_count", int'(pix_count), m_cnt);
          end
          m_cnt++;
        end
        prev_stall = pix.o_valid && !pix.i_ready;
        pr = int'(pix.o_red); pg = int'(pix.o_green); pb = int'(pix.o_blue);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1; cfg_load = 1'b0; mode = 2'd0; wr = '0; wg = '0; wb = '0; thresh = '0;
    pix.i_valid = 1'b0; pix.i_ready = 1'b1;
    pix.i_red = '0; pix.i_green = '0; pix.i_blue = '0;
    @(negedge clk);
    cycle(acc); cycle(acc);
    rst = 1'b0;
    chk("rst_valid", int'(pix.o_valid), 0);
    chk("rst_red", int'(pix.o_red), 0);
    chk("rst_green", int'(pix.o_green), 0);
    chk("rst_blue", int'(pix.o_blue), 0);
    chk("rst_count", int'(pix_count), 0);

    // Default weights, latency and values
    send(12'hFFF, 12'hFFF, 12'hFFF);
    chk("lat_s1_valid", int'(pix.o_valid), 0);
    send(12'h800, 12'h400, 12'h000);
    chk("lat_out_valid", int'(pix.o_valid), 1);
    chk("lat_out_red", int'(pix.o_red), 12'hFFF);
    idle(3);
    chk("count_after_2", int'(pix_count), 2);

    // Load 15/15/15 in the same cycle a pixel is accepted
    wr = 4'd15; wg = 4'd15; wb = 4'd15; mode = 2'd1; cfg_load = 1'b1;
    send(12'h100, 12'h100, 12'h100);
    send(12'hFFF, 12'hFFF, 12'hFFF);
    idle(3);

    // Stream 8 greys with a 5-cycle downstream stall
    load_cfg(3, 3, 2, 1);
    for (int v = 1; v <= 4; v++) send(v * 16, v * 16, v * 16);
    rdy_mode = 2;
    pix.i_red = 12'h050; pix.i_green = 12'h050; pix.i_blue = 12'h050; pix.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(acc);
      chk("stall_accept", int'(acc), 0);
      chk("stall_o_ready", int'(pix.o_ready), 0);
    end
    rdy_mode = 0;
    for (int v = 5; v <= 8; v++) send(v * 16, v * 16, v * 16);
    idle(4);
    chk("count_after_stream", int'(pix_count), 12);
    chk("stream_drained", exp_q.size(), 0);

    // Passthrough and inverted grey
    load_cfg(3, 3, 2, 0);
    send(12'h123, 12'h456, 12'h789);
    load_cfg(3, 3, 2, 2);
    send(0, 0, 0);
    idle(3);

    // Mode 3 around the threshold
    load_cfg(3, 3, 2, 3);
    thresh = 12'h800;
    send(12'h7FF, 12'h7FF, 12'h7FF);
    send(12'h800, 12'h800, 12'h800);
    idle(3);

    // Reset with two pixels in flight
    load_cfg(15, 15, 15, 1);
    send(12'h111, 12'h222, 12'h333);
    send(12'h444, 12'h555, 12'h666);
    rst = 1'b1; rdy_mode = 2;
    cycle(acc);
    rst = 1'b0; rdy_mode = 0;
    chk("midrst_valid", int'(pix.o_valid), 0);
    chk("midrst_count", int'(pix_count), 0);
    idle(4);
    send(12'h100, 12'h200, 12'h300);
    idle(3);
    chk("postrst_count", int'(pix_count), 1);

    // Randomised traffic with random backpressure and config changes
    rdy_mode = 1;
    for (int it = 0; it < 300; it++) begin
      thresh = DW'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        wr = WW'($urandom); wg = WW'($urandom); wb = WW'($urandom);
        mode = 2'($urandom); cfg_load = 1'b1;
      end
      if ($urandom_range(0, 9) < 7) send(int'(DW'($urandom)), int'(DW'($urandom)),
                                         int'(DW'($urandom)));
      else idle(1);
    end
    rdy_mode = 0;
    idle(6);
    chk("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
